// File: rtl/dm_store_lane.sv
// MEM-stage data memory: byte-lane store merge, alignment/range checks,
// raw word read-back for the load extender.
module dm_store_lane #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  StoreOp,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic        err_align,
  output logic        err_range,
  output logic [3:0]  last_be,
  output logic [31:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  aligned;
  logic                  commit;
  logic [3:0]            be_dec;
  logic [31:0]           wlane;
  logic [31:0]           wmask;

  assign idx      = addr[DEPTH_LOG2+1:2];
  assign in_range = (addr[31:DEPTH_LOG2+2] == '0);

  always_comb begin
    aligned = 1'b0;
    be_dec  = 4'b0000;
    wlane   = wdata;
    unique case (1'b1)
      (StoreOp == 2'b00): begin
        aligned = (addr[1:0] == 2'b00);
        be_dec  = 4'b1111;
        wlane   = wdata;
      end
      (StoreOp == 2'b01): begin
        aligned = ~addr[0];
        be_dec  = addr[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata[15:0]}};
      end
      (StoreOp == 2'b10): begin
        aligned = 1'b1;
        be_dec  = 4'b0001 << addr[1:0];
        wlane   = {4{wdata[7:0]}};
      end
      default: begin
        aligned = 1'b0;
        be_dec  = 4'b0000;
        wlane   = wdata;
      end
    endcase
  end

  assign commit = we & aligned & in_range & ~reset;
  assign be     = commit ? be_dec : 4'b0000;

  always_comb begin
    wmask = '0;
    for (int k = 0; k < 4; k++) begin
      wmask[8*k +: 8] = {8{be_dec[k]}};
    end
  end

  // Replicated lanes let the mask pick the narrowed data into any lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wlane & wmask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_align <= 1'b0;
      err_range <= 1'b0;
      last_be   <= 4'b0000;
      wr_count  <= '0;
    end else begin
      err_align <= we & ~aligned;
      err_range <= we & ~in_range;
      if (commit) begin
        last_be  <= be_dec;
        wr_count <= wr_count + 32'd1;
      end
    end
  end

  assign rdata = in_range ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_dm_store_lane.sv
// Bench for dm_store_lane: directed table, random run against a
// byte-level memory model, reset and counter-wrap sequences.
module tb_dm_store_lane;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  StoreOp;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        err_align;
  logic        err_range;
  logic [3:0]  last_be;
  logic [31:0] wr_count;

  dm_store_lane #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset), .we(we), .StoreOp(StoreOp),
    .addr(addr), .wdata(wdata), .rdata(rdata), .be(be),
    .err_align(err_align), .err_range(err_range),
    .last_be(last_be), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mm [1024];
  logic        m_ea, m_er;
  logic [3:0]  m_lbe;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] op);
    case (op)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a < 32'd4096) return mm[a / 4];
    return 32'h0;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 1024; i++) mm[i] = '0;
    m_ea = 0; m_er = 0; m_lbe = 0; m_cnt = 0;
  endtask

  task automatic step(input logic r, input logic w, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] d);
    int n, off;
    logic al, inr, com;
    logic [3:0] ebe;
    logic [31:0] word;
    @(negedge clk);
    reset = r; we = w; StoreOp = op; addr = a; wdata = d;
    n   = nbytes(op);
    off = int'(a % 4);
    al  = (n != 0) && ((a % n) == 0);
    inr = a < 32'd4096;
    com = w && al && inr && !r;
    ebe = com ? 4'(((1 << n) - 1) << off) : 4'b0;
    #1;
    chk("be", {28'b0, be}, {28'b0, ebe});
    chk("rdata_pre", rdata, mread(a));
    @(posedge clk);
    #1;
    if (r) begin
      mreset();
    end else begin
      m_ea = w && !al;
      m_er = w && !inr;
      if (com) begin
        word = mm[a / 4];
        for (int k = 0; k < 4; k++)
          if (ebe[k]) word[8*k +: 8] = d[8*(k-off) +: 8];
        mm[a / 4] = word;
        m_lbe = ebe;
        m_cnt = m_cnt + 1;
      end
    end
    chk("err_align", {31'b0, err_align}, {31'b0, m_ea});
    chk("err_range", {31'b0, err_range}, {31'b0, m_er});
    chk("last_be", {28'b0, last_be}, {28'b0, m_lbe});
    chk("wr_count", wr_count, m_cnt);
    chk("rdata_post", rdata, mread(a));
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  xbe;
    logic [31:0] xrd;
    logic        xea;
    logic        xer;
    logic [3:0]  xlbe;
    logic [31:0] xcnt;
  } vec_t;

  vec_t tv [15];
  logic [3:0] seen_be;

  initial begin
    reset = 1; we = 0; StoreOp = 0; addr = 0; wdata = 0;
    mreset();
    repeat (2) @(posedge clk);

    tv[0]  = '{0, 2'b00, 32'h000, 32'h0,        4'h0, 32'h0,        0, 0, 4'h0, 0};
    tv[1]  = '{0, 2'b00, 32'hFFC, 32'h0,        4'h0, 32'h0,        0, 0, 4'h0, 0};
    tv[2]  = '{0, 2'b00, 32'h7F0, 32'h0,        4'h0, 32'h0,        0, 0, 4'h0, 0};
    tv[3]  = '{1, 2'b00, 32'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0, 0, 4'hF, 1};
    tv[4]  = '{1, 2'b10, 32'h011, 32'hFFFFFF55, 4'h2, 32'hDEAD55EF, 0, 0, 4'h2, 2};
    tv[5]  = '{1, 2'b00, 32'h020, 32'h0,        4'hF, 32'h0,        0, 0, 4'hF, 3};
    tv[6]  = '{1, 2'b01, 32'h022, 32'h1234ABCD, 4'hC, 32'hABCD0000, 0, 0, 4'hC, 4};
    tv[7]  = '{1, 2'b00, 32'h013, 32'h11111111, 4'h0, 32'hDEAD55EF, 1, 0, 4'hC, 4};
    tv[8]  = '{1, 2'b01, 32'h015, 32'h22222222, 4'h0, 32'h0,        1, 0, 4'hC, 4};
    tv[9]  = '{1, 2'b11, 32'h010, 32'h33333333, 4'h0, 32'hDEAD55EF, 1, 0, 4'hC, 4};
    tv[10] = '{0, 2'b00, 32'h010, 32'h0,        4'h0, 32'hDEAD55EF, 0, 0, 4'hC, 4};
    tv[11] = '{1, 2'b00, 32'h1000, 32'h44444444, 4'h0, 32'h0,       0, 1, 4'hC, 4};
    tv[12] = '{1, 2'b00, 32'h1001, 32'h55555555, 4'h0, 32'h0,       1, 1, 4'hC, 4};
    tv[13] = '{1, 2'b10, 32'hFFF, 32'h000000AA, 4'h8, 32'hAA000000, 0, 0, 4'h8, 5};
    tv[14] = '{1, 2'b01, 32'h7F0, 32'h0000BEEF, 4'h3, 32'h0000BEEF, 0, 0, 4'h3, 6};

    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 15; i++) begin
      fork
        begin
          @(negedge clk);
          #1 seen_be = be;
        end
        step(0, tv[i].w, tv[i].op, tv[i].a, tv[i].d);
      join
      chk($sformatf("tv%0d_be", i), {28'b0, seen_be}, {28'b0, tv[i].xbe});
      chk($sformatf("tv%0d_rdata", i), rdata, tv[i].xrd);
      chk($sformatf("tv%0d_err", i), {30'b0, err_align, err_range},
          {30'b0, tv[i].xea, tv[i].xer});
      chk($sformatf("tv%0d_last_be", i), {28'b0, last_be}, {28'b0, tv[i].xlbe});
      chk($sformatf("tv%0d_wr_count", i), wr_count, tv[i].xcnt);
    end

    // Reset wins over a simultaneous store.
    step(1, 1, 2'b00, 32'h4, 32'h5);
    chk("rst_mem1", rdata, 32'h0);
    chk("rst_cnt", wr_count, 32'h0);
    step(0, 1, 2'b00, 32'h4, 32'h5);
    chk("post_rst_mem1", rdata, 32'h5);
    chk("post_rst_cnt", wr_count, 32'h1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 4095));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
           2'($urandom_range(0, 3)), ra, $urandom());
    end

    // Counter wrap from all-ones.
    @(negedge clk);
    we = 0; reset = 0;
    force dut.wr_count = 32'hFFFFFFFF;
    #1 release dut.wr_count;
    m_cnt = 32'hFFFFFFFF;
    step(0, 1, 2'b10, 32'h40, 32'h77);
    chk("wrap_cnt", wr_count, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_store_lane.md
Name: dm_store_lane

Overview:
- Word-organised data memory with byte-lane store handling for the single-cycle MIPS datapath.
- Performs the narrowing direction of the immediate/load extender: a 32-bit register value is truncated to byte, halfword or word and merged into the addressed lane(s) of a memory word on the clock edge.
- Sits in the MEM stage between the ALU result (address), rt read data (store data) and the load extender, which receives the raw word read back.
- Flags misaligned and out-of-range stores and suppresses them.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words; default is 1024 words, 4 KiB.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  store request this cycle.
- StoreOp  input  2  store width: 2'b00 sw, 2'b01 sh, 2'b10 sb; 2'b11 is reserved.
- addr  input  32  byte address from the ALU.
- wdata  input  32  store data from rt, before truncation.
- rdata  output  32  raw word at addr[DEPTH_LOG2+1:2]; combinational.
- be  output  4  byte enable decoded for the current request; combinational, 0 when the request is not committed.
- err_align  output  1  registered; pulses 1 cycle after a misaligned store.
- err_range  output  1  registered; pulses 1 cycle after an out-of-range store.
- last_be  output  4  registered byte enable of the most recently committed store.
- wr_count  output  32  registered count of committed stores.

Behaviour:
- Reset: reset=1 at the edge clears every memory word, err_align, err_range, last_be and wr_count to 0. Reset takes priority over we; no write occurs in that cycle.
- Word index is addr[DEPTH_LOG2+1:2]. The address is in range iff addr[31:DEPTH_LOG2+2]==0.
- Alignment rules:
  - sw requires addr[1:0]==0.
  - sh requires addr[0]==0.
  - sb is always aligned.
  - StoreOp=2'b11 is treated as misaligned.
- Byte-enable decode:
  - sw gives 4'b1111.
  - sh gives 4'b0011 for addr[1]=0 and 4'b1100 for addr[1]=1.
  - sb gives 4'b0001 shifted left by addr[1:0].
- Lane placement: byte lane k holds bits [8k+7:8k].
  - sb writes wdata[7:0] into the enabled lane.
  - sh writes wdata[15:0] into the enabled half.
  - sw writes all 32 bits.
  - Upper bits of wdata beyond the store width are ignored. Unenabled lanes keep their old contents.
- Commit condition: we && aligned && in range && !reset. On commit, the masked merge is written at the edge, last_be takes be, and wr_count increments by 1. wr_count wraps 0xFFFFFFFF to 0.
- Rejected store (we=1 with a misaligned or out-of-range address):
  - No memory change; last_be and wr_count hold.
  - err_align and/or err_range = 1 for exactly the next cycle. Both flags are set if both conditions hold.
  - The error flags are 0 in any cycle following a non-erroring cycle.
- we=0: no state change except error flags returning to 0. be=0.
- Read path:
  - rdata reflects array contents, so a store at edge N is visible on rdata after edge N, with no read-during-write bypass before the edge.
  - An out-of-range addr reads 0.
  - The read ignores addr[1:0]. Lane selection and extension belong to the load extender.
- Reset asserted mid-sequence discards the pending request; the first write after reset deasserts behaves normally.

Test Plan:
- Reset, then read addr 0x0, 0xFFC, 0x7F0 -> rdata=0 each; wr_count=0; last_be=0.
- sw 0x0000_1000? No: sw addr 0x10, wdata 0xDEADBEEF, then sb addr 0x11, wdata 0xFFFFFF55 -> rdata @0x10 = 0xDEAD55EF; last_be=4'b0010; wr_count=2.
- sh addr 0x22, wdata 0x1234ABCD after sw addr 0x20, wdata 0 -> rdata=0xABCD0000; be=4'b1100 during the request.
- sw addr 0x13 and sh addr 0x15 -> memory unchanged; err_align=1 for one cycle after each; wr_count unchanged. StoreOp=2'b11 at addr 0x10 -> err_align=1.
- sw addr 0x1000 (DEPTH_LOG2=10) -> err_range=1 next cycle, no write; rdata=0 at that addr. sw addr 0x1001 -> err_align=1 and err_range=1.
- we=1 sw addr 0x4, wdata 0x5 in the same cycle as reset=1 -> mem[1]=0 and wr_count=0 after the edge. Preload wr_count to 0xFFFFFFFF via forced stores, then commit one store -> wr_count=0.
